// File: rtl/alu_iter_muldiv_pkg.sv
// Shared configuration, ALU opcodes and the multiply/divide sequencer enums.
package alu_iter_muldiv_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_ALU_ADD = 3'd0,
    OP_ALU_SUB = 3'd1,
    OP_ALU_AND = 3'd2,
    OP_ALU_OR  = 3'd3,
    OP_ALU_XOR = 3'd4
  } alu_op_e;

  typedef enum logic [1:0] {
    MD_MUL  = 2'd0,
    MD_DIVU = 2'd1,
    MD_REMU = 2'd2
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/alu_iter_muldiv_if.sv
// Request/response bundle between the execute stage and the multiply/divide sequencer.
interface alu_iter_muldiv_if;
  import alu_iter_muldiv_pkg::*;

  localparam int unsigned XLEN = DATA_WIDTH;

  logic            start_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            kill_i;
  logic            ready_o;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, op_i, a_i, b_i, kill_i,
    input  ready_o, busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, kill_i,
    output ready_o, busy_o, done_o, result_o
  );

endinterface

// File: rtl/alu_iter_muldiv_alu.sv
// Small combinational ALU shared by the iterative multiply/divide sequencer.
module alu_unit
  import alu_iter_muldiv_pkg::*;
#(
  parameter int unsigned XLEN = DATA_WIDTH
) (
  input  alu_op_e         alu_op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o
);

  always_comb begin
    result_o = '0;
    unique case (alu_op_i)
      OP_ALU_ADD: result_o = a_i + b_i;
      OP_ALU_SUB: result_o = a_i - b_i;
      OP_ALU_AND: result_o = a_i & b_i;
      OP_ALU_OR:  result_o = a_i | b_i;
      OP_ALU_XOR: result_o = a_i ^ b_i;
      default:    result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_iter_muldiv.sv
// Iterative MUL / DIVU / REMU sequencer: one shift-add or restoring-divide step per cycle,
// XLEN steps per operation, driving a private alu_unit.
module alu_iter_muldiv
  import alu_iter_muldiv_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  alu_iter_muldiv_if.slave   md_if
);

  localparam int unsigned XLEN  = DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(XLEN);

  md_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_op;
  logic [XLEN-1:0]  r_acc;    // MUL accumulator / DIV partial remainder
  logic [XLEN-1:0]  r_opa;    // MUL multiplicand (shifts left) / DIV divisor (static)
  logic [XLEN-1:0]  r_opb;    // MUL multiplier (shifts right) / DIV dividend (shifts left)
  logic [XLEN-1:0]  r_quo;
  logic [XLEN-1:0]  r_result;

  logic            w_iter, w_last, w_accept, w_is_div, w_in_div, w_ge;
  logic [XLEN-1:0] w_rs, w_alu_a, w_alu_y, w_acc_nxt, w_quo_nxt;
  alu_op_e         w_alu_op;

  assign w_iter   = (r_state == S_ITER);
  assign w_last   = w_iter && (r_cnt == CNT_W'(XLEN - 1));
  assign w_accept = md_if.start_i && !md_if.kill_i && !w_iter;
  assign w_is_div = (r_op == MD_DIVU) || (r_op == MD_REMU);
  assign w_in_div = (md_if.op_i == MD_DIVU) || (md_if.op_i == MD_REMU);

  // Restoring divide: shift in next dividend bit; a bit shifted out of rem forces ge.
  assign w_rs = {r_acc[XLEN-2:0], r_opb[XLEN-1]};
  assign w_ge = {r_acc[XLEN-1], w_rs} >= {1'b0, r_opa};

  assign w_alu_op = (w_iter && w_is_div) ? OP_ALU_SUB : OP_ALU_ADD;
  assign w_alu_a  = w_is_div ? w_rs : r_acc;

  alu_unit #(
    .XLEN (XLEN)
  ) u_alu (
    .alu_op_i (w_alu_op),
    .a_i      (w_alu_a),
    .b_i      (r_opa),
    .result_o (w_alu_y)
  );

  assign w_acc_nxt = w_is_div ? (w_ge ? w_alu_y : w_rs) : (r_opb[0] ? w_alu_y : r_acc);
  assign w_quo_nxt = {r_quo[XLEN-2:0], w_ge};

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (md_if.start_i) w_state_nxt = S_ITER;
      S_ITER:  if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = md_if.start_i ? S_ITER : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (md_if.kill_i) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_acc    <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_quo    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_op  <= md_if.op_i;
      r_acc <= '0;
      r_quo <= '0;
      r_opa <= w_in_div ? md_if.b_i : md_if.a_i;
      r_opb <= w_in_div ? md_if.a_i : md_if.b_i;
    end else if (w_iter && !md_if.kill_i) begin
      r_cnt <= r_cnt + CNT_W'(1);
      r_acc <= w_acc_nxt;
      r_quo <= w_quo_nxt;
      if (w_is_div) begin
        r_opb <= r_opb << 1;
      end else begin
        r_opa <= r_opa << 1;
        r_opb <= r_opb >> 1;
      end
      if (w_last) begin
        unique case (r_op)
          MD_MUL:  r_result <= w_acc_nxt;
          MD_DIVU: r_result <= w_quo_nxt;
          MD_REMU: r_result <= w_acc_nxt;
          default: r_result <= '0;
        endcase
      end
    end
  end

  assign md_if.ready_o  = !w_iter;
  assign md_if.busy_o   = w_iter;
  assign md_if.done_o   = (r_state == S_DONE);
  assign md_if.result_o = r_result;

endmodule
